shift_sub_divider: RTL and testbench

//  Sequential restoring (shift-subtract) unsigned divider; inverse datapath of the shift-add multiplier.

---
 rtl/shift_sub_divider.sv | 96 +++++++++
 tb/tb_shift_sub_divider.sv | 114 +++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring unsigned divider, one shift and one subtract cycle per quotient bit.
module shift_sub_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;
  state_t state_q, state_d;
  logic [N:0]    rem_q, rem_d, trial;
  logic [N-1:0]  qw_q, qw_d, dvs_q, dvs_d, quo_q, quo_d, rmd_q, rmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d, ge;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      qw_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qw_q    <= qw_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end
  // rem stays below 2*divisor after a shift, so N+1 bits suffice for the trial subtract
  assign trial = rem_q - {1'b0, dvs_q};
  assign ge    = rem_q >= {1'b0, dvs_q};
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        if (divisor == '0) begin
          quo_d   = '1;
          rmd_d   = dividend;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = '0;
          qw_d    = dividend;
          dvs_d   = divisor;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {rem_d, qw_d} = {rem_q[N-1:0], qw_q, 1'b0};
        state_d       = SUB;
      end
      SUB: begin
        rem_d = ge ? trial : rem_q;
        qw_d  = {qw_q[N-1:1], ge};
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = qw_d;
          rmd_d   = rem_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = SHIFT;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  assign busy        = (state_q == SHIFT) || (state_q == SUB);
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider: directed scoreboard bench for the 4-bit shift-subtract divider.
module tb_shift_sub_divider;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  typedef struct packed {logic [3:0] q; logic [3:0] r; logic z;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic [3:0] last_q = '0;
  int         nvec = 0, nerr = 0;

  shift_sub_divider #(.N(4)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive a request just after an edge; the next edge accepts it (edge 1)
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit push);
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    if (push) sb.push_back(exp_t'{q: (b == 0) ? 4'hF : a / b, r: (b == 0) ? a : a % b, z: b == 0});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // called #1 after edge lat0; waits for done and checks latency, busy count and result
  task automatic wait_done(input int lat0, input int exp_lat, input int exp_busy);
    int lat = lat0;
    int nbusy = (lat0 > 1) ? lat0 - 1 : 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      check("hold_quotient", quotient, last_q);
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", lat, exp_lat);
    check("busy_cycles", nbusy, exp_busy);
    if (sb.size() == 0) check("scoreboard_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", div_by_zero, e.z);
      last_q = e.q;
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    start = 1'b0;
    n_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_done", done, 0);
    launch(13, 4, 1); wait_done(1, 9, 8);
    launch(15, 1, 1); wait_done(1, 9, 8);
    launch(5, 7, 1);  wait_done(1, 9, 8);
    launch(15, 15, 1); wait_done(1, 9, 8);
    launch(0, 3, 1);  wait_done(1, 9, 8);
    launch(6, 0, 1);  wait_done(1, 1, 0);
    launch(9, 3, 1);  wait_done(1, 9, 8);
    // mid-operation operand change and start pulse must be ignored
    launch(13, 4, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend = 4'd2; divisor = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, 9, 8);
    // abort: asynchronous reset in the middle of an operation
    launch(13, 4, 0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    last_q = '0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done, 0);
    n_reset = 1'b1;
    launch(9, 2, 1); wait_done(1, 9, 8);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
